// File: rtl/vga_scan_render.sv
// +--------------------------------------------------------------------------+
// | vga_scan_render                                                          |
// | 640x480@60 raster, class-to-RGB mapping, sync and frame tick generation. |
// | Optional apple overlay enabled with macro APPLE_DRAW_EN.                 |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module vga_scan_render #(
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  pix_class,
`ifdef APPLE_DRAW_EN
    input  logic [6:0]  apple_x,
    input  logic [6:0]  apple_y,
`endif
    output logic [9:0]  x_pos,
    output logic [9:0]  y_pos,
    output logic        video_on,
    output logic        hsync,
    output logic        vsync,
    output logic [11:0] rgb,
    output logic        frame_tick
);

    localparam logic [9:0] c_H_VIS      = 10'(H_VIS);
    localparam logic [9:0] c_H_MAX      = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] c_HS_START   = 10'(H_VIS + H_FP);
    localparam logic [9:0] c_HS_END     = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] c_V_VIS      = 10'(V_VIS);
    localparam logic [9:0] c_V_MAX      = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] c_VS_START   = 10'(V_VIS + V_FP);
    localparam logic [9:0] c_VS_END     = 10'(V_VIS + V_FP + V_SYNC - 1);

    localparam logic [1:0] c_CLS_NONE   = 2'b00;
    localparam logic [1:0] c_CLS_HEAD   = 2'b01;
    localparam logic [1:0] c_CLS_BODY   = 2'b10;
    localparam logic [1:0] c_CLS_WALL   = 2'b11;

    localparam logic [11:0] c_RGB_BLACK = 12'h000;
    localparam logic [11:0] c_RGB_WHITE = 12'hFFF;
    localparam logic [11:0] c_RGB_RED   = 12'hF00;
    localparam logic [11:0] c_RGB_GREEN = 12'h0F0;
    localparam logic [11:0] c_RGB_APPLE = 12'hFF0;

    logic        pix_en_q,     pix_en_d;
    logic [9:0]  h_cnt_q,      h_cnt_d;
    logic [9:0]  v_cnt_q,      v_cnt_d;
    logic        video_on_q,   video_on_d;
    logic        hsync_q,      hsync_d;
    logic        vsync_q,      vsync_d;
    logic [11:0] rgb_q,        rgb_d;
    logic        frame_tick_q, frame_tick_d;

    logic        w_visible;
    logic        w_apple_hit;
    logic [11:0] w_colour;

`ifdef APPLE_DRAW_EN
    assign w_apple_hit = (h_cnt_q[9:3] == apple_x) && (v_cnt_q[9:3] == apple_y);
`else
    assign w_apple_hit = 1'b0;
`endif

    always_comb begin
        pix_en_d     = ~pix_en_q;
        h_cnt_d      = h_cnt_q;
        v_cnt_d      = v_cnt_q;
        video_on_d   = video_on_q;
        hsync_d      = hsync_q;
        vsync_d      = vsync_q;
        rgb_d        = rgb_q;
        // Tick is re-evaluated every clk so it lasts exactly one clk.
        frame_tick_d = pix_en_q && (h_cnt_q == c_H_MAX) && (v_cnt_q == c_V_MAX);

        w_visible = (h_cnt_q < c_H_VIS) && (v_cnt_q < c_V_VIS);

        case (pix_class)
            c_CLS_WALL: w_colour = c_RGB_WHITE;
            c_CLS_HEAD: w_colour = c_RGB_RED;
            c_CLS_BODY: w_colour = c_RGB_GREEN;
            c_CLS_NONE: w_colour = w_apple_hit ? c_RGB_APPLE : c_RGB_BLACK;
            default:    w_colour = c_RGB_BLACK;
        endcase

        if (pix_en_q) begin
            video_on_d = w_visible;
            hsync_d    = !((h_cnt_q >= c_HS_START) && (h_cnt_q <= c_HS_END));
            vsync_d    = !((v_cnt_q >= c_VS_START) && (v_cnt_q <= c_VS_END));
            rgb_d      = w_visible ? w_colour : c_RGB_BLACK;

            if (h_cnt_q == c_H_MAX) begin
                h_cnt_d = 10'd0;
                v_cnt_d = (v_cnt_q == c_V_MAX) ? 10'd0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pix_en_q     <= 1'b0;
            h_cnt_q      <= 10'd0;
            v_cnt_q      <= 10'd0;
            video_on_q   <= 1'b0;
            hsync_q      <= 1'b1;
            vsync_q      <= 1'b1;
            rgb_q        <= c_RGB_BLACK;
            frame_tick_q <= 1'b0;
        end else begin
            pix_en_q     <= pix_en_d;
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            video_on_q   <= video_on_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            rgb_q        <= rgb_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign x_pos      = h_cnt_q;
    assign y_pos      = v_cnt_q;
    assign video_on   = video_on_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign rgb        = rgb_q;
    assign frame_tick = frame_tick_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_scan_render.sv
// +--------------------------------------------------------------------------+
// | tb_vga_scan_render                                                       |
// | Randomized bench: full-size raster plus a shrunken raster for frames.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_vga_scan_render;

`ifdef APPLE_DRAW_EN
    localparam bit c_APPLE = 1'b1;
`else
    localparam bit c_APPLE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  pix_class;
    logic [6:0]  apple_x;
    logic [6:0]  apple_y;

    logic [9:0]  d_x, d_y, s_x, s_y;
    logic        d_von, d_hs, d_vs, d_ft, s_von, s_hs, s_vs, s_ft;
    logic [11:0] d_rgb, s_rgb;

    always #10 clk = ~clk;

    vga_scan_render u_dut (
        .clk        (clk),
        .rst        (rst),
        .pix_class  (pix_class),
`ifdef APPLE_DRAW_EN
        .apple_x    (apple_x),
        .apple_y    (apple_y),
`endif
        .x_pos      (d_x),
        .y_pos      (d_y),
        .video_on   (d_von),
        .hsync      (d_hs),
        .vsync      (d_vs),
        .rgb        (d_rgb),
        .frame_tick (d_ft)
    );

    // Shrunken timing so several whole frames fit in a short run.
    vga_scan_render #(
        .H_VIS(20), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_VIS(6),  .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) u_dut_s (
        .clk        (clk),
        .rst        (rst),
        .pix_class  (pix_class),
`ifdef APPLE_DRAW_EN
        .apple_x    (apple_x),
        .apple_y    (apple_y),
`endif
        .x_pos      (s_x),
        .y_pos      (s_y),
        .video_on   (s_von),
        .hsync      (s_hs),
        .vsync      (s_vs),
        .rgb        (s_rgb),
        .frame_tick (s_ft)
    );

    int         vec_cnt = 0;
    int         err_cnt = 0;
    int         k = 0;
    bit         started = 1'b0;
    logic [1:0] samp_cls = 2'b00;
    logic [6:0] samp_ax = 7'd0;
    logic [6:0] samp_ay = 7'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            if (err_cnt <= 40)
                $display("FAIL %s: got %0h, expected %0h (clk %0d after reset)", tag, obs, exp, k);
        end
    endtask

    // Reference: after k clks out of reset, m = k/2 pixels have been scanned.
    // Registered outputs describe pixel m-1 using the class sampled at clk 2m.
    function automatic void model(
        input int k_in, input logic [1:0] cls, input logic [6:0] ax, input logic [6:0] ay,
        input int hv, input int hfp, input int hs, input int hbp,
        input int vv, input int vfp, input int vs, input int vbp,
        output logic [9:0] ex, output logic [9:0] ey, output logic ev,
        output logic ehs, output logic evs, output logic [11:0] ergb, output logic eft);
        int ht, vt, m, p, ph, pv;
        ht   = hv + hfp + hs + hbp;
        vt   = vv + vfp + vs + vbp;
        m    = k_in / 2;
        ex   = 10'(m % ht);
        ey   = 10'((m / ht) % vt);
        ev   = 1'b0;
        ehs  = 1'b1;
        evs  = 1'b1;
        ergb = 12'h000;
        eft  = 1'b0;
        if (m > 0) begin
            p   = m - 1;
            ph  = p % ht;
            pv  = (p / ht) % vt;
            ev  = (ph < hv) && (pv < vv);
            ehs = !((ph >= hv + hfp) && (ph < hv + hfp + hs));
            evs = !((pv >= vv + vfp) && (pv < vv + vfp + vs));
            eft = (k_in % 2 == 0) && (p % (ht * vt) == ht * vt - 1);
            if (ev) begin
                case (cls)
                    2'b11:   ergb = 12'hFFF;
                    2'b01:   ergb = 12'hF00;
                    2'b10:   ergb = 12'h0F0;
                    default: ergb = (c_APPLE && (ph / 8 == int'(ax)) && (pv / 8 == int'(ay)))
                                    ? 12'hFF0 : 12'h000;
                endcase
            end
        end
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            k       <= 0;
            started <= 1'b1;
        end else begin
            k <= k + 1;
            if ((k + 1) % 2 == 0) begin
                samp_cls <= pix_class;
                samp_ax  <= apple_x;
                samp_ay  <= apple_y;
            end
        end
    end

    task automatic check_all();
        logic [9:0]  ex, ey;
        logic        ev, ehs, evs, eft;
        logic [11:0] ergb;
        model(k, samp_cls, samp_ax, samp_ay, 640, 16, 96, 48, 480, 10, 2, 33,
              ex, ey, ev, ehs, evs, ergb, eft);
        chk("x_pos",      32'(d_x),   32'(ex));
        chk("y_pos",      32'(d_y),   32'(ey));
        chk("video_on",   32'(d_von), 32'(ev));
        chk("hsync",      32'(d_hs),  32'(ehs));
        chk("vsync",      32'(d_vs),  32'(evs));
        chk("rgb",        32'(d_rgb), 32'(ergb));
        chk("frame_tick", 32'(d_ft),  32'(eft));
        model(k, samp_cls, samp_ax, samp_ay, 20, 2, 4, 3, 6, 2, 2, 3,
              ex, ey, ev, ehs, evs, ergb, eft);
        chk("s_x_pos",      32'(s_x),   32'(ex));
        chk("s_y_pos",      32'(s_y),   32'(ey));
        chk("s_video_on",   32'(s_von), 32'(ev));
        chk("s_hsync",      32'(s_hs),  32'(ehs));
        chk("s_vsync",      32'(s_vs),  32'(evs));
        chk("s_rgb",        32'(s_rgb), 32'(ergb));
        chk("s_frame_tick", 32'(s_ft),  32'(eft));
    endtask

    // Check the state left by the last edge, then drive inputs for the next one.
    task automatic cycle(input logic r, input int mode);
        @(negedge clk);
        if (started) check_all();
        rst       = r;
        pix_class = (mode == 1) ? 2'b11 : 2'($urandom);
        if ($urandom_range(0, 63) == 0) begin
            apple_x = 7'($urandom_range(0, 3));
            apple_y = 7'($urandom_range(0, 1));
        end
    endtask

    int ft_count;

    initial begin
        rst       = 1'b0;
        pix_class = 2'b00;
        apple_x   = 7'd1;
        apple_y   = 7'd0;
        repeat (3)    cycle(1'b0, 0);
        repeat (3801) cycle(1'b1, 0);
        // Reset mid-line on the full-size raster, then restart.
        repeat (2)    cycle(1'b0, 0);
        repeat (1700) cycle(1'b1, 1);
        ft_count = 0;
        repeat (1600) begin
            cycle(1'b1, 0);
            if (s_ft) ft_count++;
        end
        // 1600 clks cover 1600/754 shrunken frames; the start phase fixes it at 2.
        chk("s_frame_tick_count", 32'(ft_count), 32'd2);
        @(negedge clk);
        check_all();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/vga_scan_render.md
# vga_scan_render

Display-side partner of the snake game logic: it generates the 640x480@60 Hz VGA raster, drives the `x_pos`/`y_pos` scan coordinates into the game block, and takes back the 2-bit pixel class (`NONE`/`HEAD`/`BODY`/`WALL`). It converts each class to 12-bit RGB and emits `hsync`/`vsync` aligned with the colour data. It also supplies a per-frame tick for game pacing. It sits between the game logic and the board VGA connector, on the 50 MHz system clock.

## Interface
Parameters:
- `H_VIS`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch
- `H_SYNC`, 96: horizontal sync width
- `H_BP`, 48: horizontal back porch
- `V_VIS`, 480: visible lines
- `V_FP`, 10: vertical front porch
- `V_SYNC`, 2: vertical sync width
- `V_BP`, 33: vertical back porch

Ports:
- `clk`, in, 1: 50 MHz system clock; one clock only
- `rst`, in, 1: reset. **Synchronous, active-low.**
- `pix_class`, in, 2: class of the pixel at the current `x_pos`/`y_pos`, from the game block. 00 NONE, 01 HEAD, 10 BODY, 11 WALL. Combinational, valid in the same clk.
- `apple_x`, in, 7: apple cell column (present only with `APPLE_DRAW_EN`)
- `apple_y`, in, 7: apple cell row (present only with `APPLE_DRAW_EN`)
- `x_pos`, out, 10: current horizontal counter, equal to `h_cnt`
- `y_pos`, out, 10: current vertical counter, equal to `v_cnt`
- `video_on`, out, 1: registered; high while the emitted pixel is visible
- `hsync`, out, 1: registered, active-low
- `vsync`, out, 1: registered, active-low
- `rgb`, out, 12: registered {R[3:0],G[3:0],B[3:0]}
- `frame_tick`, out, 1: one-clk pulse per frame

## Operation
- `pix_en` toggles every clk, giving a 25 MHz pixel rate. All counters and output registers update only on clks where `pix_en`=1.
- `h_cnt` counts 0..799 (H_VIS+H_FP+H_SYNC+H_BP−1), then wraps to 0. When `h_cnt` wraps, `v_cnt` increments; `v_cnt` wraps 524 → 0.
- Sync is low when `h_cnt` is in [656,751] and when `v_cnt` is in [490,491].
- Visible region: `h_cnt` < 640 and `v_cnt` < 480.
- Colour mapping, applied only in the visible region:
  - WALL: 12'hFFF
  - HEAD: 12'hF00
  - BODY: 12'h0F0
  - NONE: 12'h000
- Outside the visible region, `rgb` = 0 regardless of `pix_class`.
- `frame_tick` is registered. It is high for exactly one clk, the clk after the `pix_en` cycle on which `h_cnt`=799 and `v_cnt`=524.

## Timing
- Reset (sampled on the `clk` edge with `rst`=0):
  - `h_cnt`=0, `v_cnt`=0, `pix_en`=0
  - `hsync`=1, `vsync`=1, `rgb`=0, `video_on`=0, `frame_tick`=0
- The first counter advance occurs on the second clk after `rst` is released.
- Latency: `rgb`, `hsync`, `vsync` and `video_on` are registered on the same `pix_en` edge from the same `h_cnt`/`v_cnt` and the `pix_class` sampled at that edge. All four are therefore mutually aligned, one pixel (2 clk) behind `x_pos`/`y_pos`.
- `pix_class` is sampled only on `pix_en` edges. Changes between those edges are ignored.
- Counter wrap: `h_cnt` 799 → 0 and `v_cnt` 524 → 0 happen on the same `pix_en` edge.
- Reset mid-frame: on the next clk edge, all state returns to the reset values. No partial line is completed.

## Configuration
- `APPLE_DRAW_EN` defined:
  - Adds the `apple_x`/`apple_y` ports.
  - In the visible region, when `pix_class`=NONE, `x_pos[9:3]`=`apple_x` and `y_pos[9:3]`=`apple_y`, then `rgb`=12'hFF0.
  - WALL, HEAD and BODY take priority over the apple.
- Undefined: the ports are absent and the NONE class always renders 12'h000.

## Test plan
- Reset then free-run 2×800×525 clk: `frame_tick` pulses exactly once per 840 000 clk. `hsync` low 192 clk per 1600-clk line; `vsync` low 3200 clk per frame.
- `pix_class` tied to 2'b11: `rgb`=12'hFFF only while `video_on`=1, and 0 during the porches and sync.
- Drive `pix_class`=01 only when `x_pos`=100, `y_pos`=50: exactly one pixel of `rgb`=12'hF00 appears 2 clk later, with `video_on`=1.
- Assert `rst`=0 at `h_cnt`=300, `v_cnt`=200: next edge gives `x_pos`=0, `y_pos`=0, `hsync`=`vsync`=1, `rgb`=0. The raster then restarts cleanly.
- With `APPLE_DRAW_EN`, `apple_x`=20, `apple_y`=10, `pix_class`=0: `rgb`=12'hFF0 exactly for `x_pos` 160..167 and `y_pos` 80..87. Forcing `pix_class`=10 there gives 12'h0F0.
- Boundary: at `x_pos`=639 the colour is shown; at `x_pos`=640 (and `y_pos`=480), `rgb`=0 and `video_on`=0.
